lifo_stack: RTL and testbench

LIFO_STACK -- requirements
Module: lifo_stack

---
 rtl/lifo_stack_pkg.sv | 13 +
 rtl/lifo_stack_if.sv | 43 ++++
 rtl/lifo_stack_mem.sv | 22 ++
 rtl/lifo_stack.sv | 81 ++++++++
 tb/tb_lifo_stack.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/lifo_stack_pkg.sv
// lifo_stack_pkg: operation encoding and push/pop decode shared by the LIFO stack
package lifo_stack_pkg;

  typedef enum logic [1:0] {OP_NONE, OP_PUSH, OP_POP, OP_REPLACE} stack_op_e;

  // A pop against an empty stack is never honoured, so push+pop on empty is a plain push
  function automatic stack_op_e decode_op(input logic push, input logic pop, input logic empty);
    return (push && pop && !empty) ? OP_REPLACE :
           push                    ? OP_PUSH    :
           (pop && !empty)         ? OP_POP     : OP_NONE;
  endfunction

endpackage

// File: rtl/lifo_stack_if.sv
// lifo_stack_if: push/pop bus of the LIFO stack; error flag signals exist only with LIFO_STACK_ERR_FLAGS_EN
interface lifo_stack_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);

  logic                     push;
  logic                     pop;
  logic [WIDTH-1:0]         data_in;
  logic [WIDTH-1:0]         top;
  logic [WIDTH-1:0]         pop_data;
  logic                     pop_valid;
  logic [$clog2(DEPTH):0]   count;
  logic                     empty;
  logic                     full;

`ifdef LIFO_STACK_ERR_FLAGS_EN
  logic                     overflow;
  logic                     underflow;
  logic                     clear_err;

  modport master (
    output push, pop, data_in, clear_err,
    input  top, pop_data, pop_valid, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, data_in, clear_err,
    output top, pop_data, pop_valid, count, empty, full, overflow, underflow
  );
`else
  modport master (
    output push, pop, data_in,
    input  top, pop_data, pop_valid, count, empty, full
  );

  modport slave (
    input  push, pop, data_in,
    output top, pop_data, pop_valid, count, empty, full
  );
`endif

endinterface

// File: rtl/lifo_stack_mem.sv
// lifo_stack_mem: storage array with one synchronous write port and one combinational read port
module lifo_stack_mem #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack.sv
// lifo_stack: circular-buffer LIFO with overwrite-or-reject on full; error flags with LIFO_STACK_ERR_FLAGS_EN
module lifo_stack
  import lifo_stack_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int OVERWRITE = 1
) (
  input  logic          clock,
  input  logic          reset,
  lifo_stack_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    ptr;
  logic [AW:0]      cnt;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] pop_data;
  logic             pop_valid;
  logic             empty;
  logic             full;
  logic             push_ok;
  logic             take;
  stack_op_e        op;

  assign empty   = cnt == '0;
  assign full    = cnt == (AW+1)'(DEPTH);
  assign op      = decode_op(bus.push, bus.pop, empty);
  assign take    = op == OP_POP || op == OP_REPLACE;
  // A push at full only advances the pointer when overwriting; count saturates at DEPTH
  assign push_ok = op == OP_PUSH && (!full || OVERWRITE != 0);

  lifo_stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clock (clock),
    .we    (push_ok || op == OP_REPLACE),
    .waddr (op == OP_REPLACE ? ptr - AW'(1) : ptr),
    .wdata (bus.data_in),
    .raddr (ptr - AW'(1)),
    .rdata (rdata)
  );

  always_ff @(posedge clock)
    if (reset) begin
      ptr       <= '0;
      cnt       <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
    end else begin
      pop_valid <= take;
      if (take) pop_data <= rdata;
      ptr <= push_ok ? ptr + AW'(1) : op == OP_POP ? ptr - AW'(1) : ptr;
      cnt <= (push_ok && !full) ? cnt + 1'b1 : op == OP_POP ? cnt - 1'b1 : cnt;
    end

  assign bus.top       = empty ? '0 : rdata;
  assign bus.pop_data  = pop_data;
  assign bus.pop_valid = pop_valid;
  assign bus.count     = cnt;
  assign bus.empty     = empty;
  assign bus.full      = full;

`ifdef LIFO_STACK_ERR_FLAGS_EN
  logic overflow;
  logic underflow;

  // A fresh event outranks clear_err in the same cycle
  always_ff @(posedge clock)
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (op == OP_PUSH && full) || (overflow && !bus.clear_err);
      underflow <= (bus.pop && empty) || (underflow && !bus.clear_err);
    end

  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: directed bench driving an overwrite and a reject stack side by side against a stack model
module tb_lifo_stack;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  lifo_stack_if #(.WIDTH(16), .DEPTH(8)) b1 ();
  lifo_stack_if #(.WIDTH(16), .DEPTH(8)) b0 ();

  lifo_stack #(.WIDTH(16), .DEPTH(8), .OVERWRITE(1)) dut1 (.clock(clock), .reset(reset), .bus(b1));
  lifo_stack #(.WIDTH(16), .DEPTH(8), .OVERWRITE(0)) dut0 (.clock(clock), .reset(reset), .bus(b0));

  int passed = 0;
  int total  = 0;

  // Model: index 0 is the bottom of the stack, mc is the entry count
  logic [15:0] ms [2][8];
  int          mc [2];
  bit          pv [2];
  bit          ovf [2];
  bit          udf [2];
  logic [15:0] lastpd [2];
  logic [15:0] sb0 [$];
  logic [15:0] sb1 [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input bit p, input bit q, input logic [15:0] d, input bit ce);
    b1.push = p; b1.pop = q; b1.data_in = d;
    b0.push = p; b0.pop = q; b0.data_in = d;
`ifdef LIFO_STACK_ERR_FLAGS_EN
    b1.clear_err = ce; b0.clear_err = ce;
`endif
  endtask

  task automatic check_all(input string tag);
    for (int m = 0; m < 2; m++) begin
      if (pv[m]) begin
        if (m == 1 && sb1.size() > 0) lastpd[m] = sb1.pop_front();
        else if (m == 0 && sb0.size() > 0) lastpd[m] = sb0.pop_front();
      end
      chk({tag, m ? "/ow pop_valid" : "/rj pop_valid"}, m ? b1.pop_valid : b0.pop_valid, pv[m]);
      chk({tag, m ? "/ow pop_data" : "/rj pop_data"}, m ? b1.pop_data : b0.pop_data, lastpd[m]);
      chk({tag, m ? "/ow top" : "/rj top"}, m ? b1.top : b0.top, mc[m] > 0 ? ms[m][mc[m]-1] : 16'h0);
      chk({tag, m ? "/ow count" : "/rj count"}, m ? b1.count : b0.count, mc[m]);
      chk({tag, m ? "/ow empty" : "/rj empty"}, m ? b1.empty : b0.empty, mc[m] == 0);
      chk({tag, m ? "/ow full" : "/rj full"}, m ? b1.full : b0.full, mc[m] == 8);
`ifdef LIFO_STACK_ERR_FLAGS_EN
      chk({tag, m ? "/ow overflow" : "/rj overflow"}, m ? b1.overflow : b0.overflow, ovf[m]);
      chk({tag, m ? "/ow underflow" : "/rj underflow"}, m ? b1.underflow : b0.underflow, udf[m]);
`endif
    end
  endtask

  task automatic step(input string tag, input bit p, input bit q, input logic [15:0] d, input bit ce = 1'b0);
    drive(p, q, d, ce);
    for (int m = 0; m < 2; m++) begin
      pv[m] = 1'b0;
      if (ce) begin ovf[m] = 1'b0; udf[m] = 1'b0; end
      if (q && mc[m] > 0) begin
        pv[m] = 1'b1;
        if (m == 1) sb1.push_back(ms[m][mc[m]-1]);
        else sb0.push_back(ms[m][mc[m]-1]);
        if (p) ms[m][mc[m]-1] = d;
        else mc[m]--;
      end else begin
        if (q) udf[m] = 1'b1;
        if (p && mc[m] < 8) begin
          ms[m][mc[m]] = d;
          mc[m]++;
        end else if (p) begin
          ovf[m] = 1'b1;
          if (m == 1) begin
            for (int i = 0; i < 7; i++) ms[m][i] = ms[m][i+1];
            ms[m][7] = d;
          end
        end
      end
    end
    @(posedge clock); #1;
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag, input bit p, input logic [15:0] d);
    reset = 1'b1;
    drive(p, 1'b0, d, 1'b0);
    for (int m = 0; m < 2; m++) begin
      mc[m] = 0; pv[m] = 1'b0; ovf[m] = 1'b0; udf[m] = 1'b0; lastpd[m] = 16'h0;
    end
    sb0.delete(); sb1.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    check_all(tag);
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    @(posedge clock); #1;
    do_reset("reset", 1'b0, 16'h0);

    step("push11", 1, 0, 16'h0011);
    step("push22", 1, 0, 16'h0022);
    step("push33", 1, 0, 16'h0033);
    for (int i = 0; i < 3; i++) step("pop3", 0, 1, 16'h0);
    step("pop_empty", 0, 1, 16'h0);
    step("idle_after_pop", 0, 0, 16'h0);
    step("clear_err", 0, 0, 16'h0, 1'b1);
    step("clear_vs_underflow", 0, 1, 16'h0, 1'b1);
    step("pushpop_empty", 1, 1, 16'h0077);
    step("pop77", 0, 1, 16'h0);
    step("clear_err2", 0, 0, 16'h0, 1'b1);

    for (int i = 1; i <= 9; i++) step("fill", 1, 0, 16'(i));
    step("replace_full", 1, 1, 16'h00F0);
    step("replace_back", 1, 1, 16'h0009);
    for (int i = 0; i < 8; i++) step("drain", 0, 1, 16'h0);
    step("clear_err3", 0, 0, 16'h0, 1'b1);

    step("pushAA", 1, 0, 16'h00AA);
    step("replaceBB", 1, 1, 16'h00BB);
    step("popBB", 0, 1, 16'h0);

    step("pre_rst1", 1, 0, 16'h0101);
    step("pre_rst2", 1, 0, 16'h0202);
    step("pre_rst3", 1, 0, 16'h0303);
    do_reset("reset_mid", 1'b1, 16'h0055);
    step("push44", 1, 0, 16'h0044);

    for (int i = 0; i < 60; i++)
      step("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 16'($urandom), 1'($urandom_range(0, 7) == 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
